// File: rtl/axis_c2h_arbiter.sv
// Packet-granular round-robin arbiter sharing one XDMA C2H AXI-Stream channel
// among N_REQ sources, with a registered 2-entry skid buffer on the output.
module axis_c2h_arbiter #(
   parameter int N_REQ        = 4,
   parameter int C_DATA_WIDTH = 128,
   localparam int GRANT_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic                            axis_aclk,
   input  logic                            axis_areset,
   input  logic                            arb_en,
   input  logic [N_REQ-1:0]                s_axis_tvalid,
   output logic [N_REQ-1:0]                s_axis_tready,
   input  logic [N_REQ*C_DATA_WIDTH-1:0]   s_axis_tdata,
   input  logic [N_REQ*C_DATA_WIDTH/8-1:0] s_axis_tkeep,
   input  logic [N_REQ-1:0]                s_axis_tlast,
   output logic                            m_axis_tvalid,
   input  logic                            m_axis_tready,
   output logic [C_DATA_WIDTH-1:0]         m_axis_tdata,
   output logic [C_DATA_WIDTH/8-1:0]       m_axis_tkeep,
   output logic                            m_axis_tlast,
   output logic                            grant_valid,
   output logic [GRANT_W-1:0]              grant_idx,
   output logic [31:0]                     pkt_cnt
);

   localparam int KEEP_W = C_DATA_WIDTH/8;

   typedef enum logic {IDLE, XFER} state_t;

   state_t               state, state_next;
   logic [GRANT_W-1:0]   last_grant, last_grant_next, grant_idx_next;
   logic [GRANT_W-1:0]   pick, cand;
   logic                 grant_valid_next, found;

   logic [C_DATA_WIDTH-1:0] in_data;
   logic [KEEP_W-1:0]       in_keep;
   logic                    in_last, in_valid;
   logic                    push, pop, room;

   logic [C_DATA_WIDTH-1:0] e1_data;
   logic [KEEP_W-1:0]       e1_keep;
   logic                    e1_last, e1_valid;

   always_comb begin
      in_data  = '0;
      in_keep  = '0;
      in_last  = 1'b0;
      in_valid = 1'b0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         if (grant_idx == GRANT_W'(i)) begin
            in_data  = s_axis_tdata[i*C_DATA_WIDTH +: C_DATA_WIDTH];
            in_keep  = s_axis_tkeep[i*KEEP_W +: KEEP_W];
            in_last  = s_axis_tlast[i];
            in_valid = s_axis_tvalid[i];
         end
      end
   end

   // Second skid entry is the only thing that can be full, so its flag is the registered not-full.
   assign room = ~e1_valid;
   assign push = (state == XFER) && in_valid && room;
   assign pop  = m_axis_tvalid && m_axis_tready;

   always_comb begin
      s_axis_tready = '0;
      if (state == XFER)
         s_axis_tready[grant_idx] = room;
   end

   always_comb begin
      found = 1'b0;
      pick  = last_grant;
      cand  = '0;
      for (int unsigned k = 1; k <= N_REQ; k++) begin
         cand = GRANT_W'((32'(last_grant) + k) % N_REQ);
         if (!found && s_axis_tvalid[cand]) begin
            found = 1'b1;
            pick  = cand;
         end
      end
   end

   always_comb begin
      state_next       = state;
      grant_idx_next   = grant_idx;
      grant_valid_next = grant_valid;
      last_grant_next  = last_grant;
      case (state)
         IDLE: begin
            if (arb_en && found) begin
               state_next       = XFER;
               grant_idx_next   = pick;
               grant_valid_next = 1'b1;
            end
         end
         XFER: begin
            if (push && in_last) begin
               state_next       = IDLE;
               grant_valid_next = 1'b0;
               last_grant_next  = grant_idx;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge axis_aclk or posedge axis_areset) begin
      if (axis_areset) begin
         state       <= IDLE;
         grant_idx   <= '0;
         grant_valid <= 1'b0;
         last_grant  <= GRANT_W'(N_REQ-1);
      end else begin
         state       <= state_next;
         grant_idx   <= grant_idx_next;
         grant_valid <= grant_valid_next;
         last_grant  <= last_grant_next;
      end
   end

   always_ff @(posedge axis_aclk or posedge axis_areset) begin
      if (axis_areset) begin
         m_axis_tvalid <= 1'b0;
         m_axis_tdata  <= '0;
         m_axis_tkeep  <= '0;
         m_axis_tlast  <= 1'b0;
         e1_valid      <= 1'b0;
         e1_data       <= '0;
         e1_keep       <= '0;
         e1_last       <= 1'b0;
         pkt_cnt       <= '0;
      end else begin
         if (pop && m_axis_tlast)
            pkt_cnt <= pkt_cnt + 32'd1;
         case ({push, pop})
            2'b10: begin
               if (!m_axis_tvalid) begin
                  m_axis_tvalid <= 1'b1;
                  m_axis_tdata  <= in_data;
                  m_axis_tkeep  <= in_keep;
                  m_axis_tlast  <= in_last;
               end else begin
                  e1_valid <= 1'b1;
                  e1_data  <= in_data;
                  e1_keep  <= in_keep;
                  e1_last  <= in_last;
               end
            end
            2'b01: begin
               if (e1_valid) begin
                  m_axis_tdata <= e1_data;
                  m_axis_tkeep <= e1_keep;
                  m_axis_tlast <= e1_last;
                  e1_valid     <= 1'b0;
               end else begin
                  m_axis_tvalid <= 1'b0;
               end
            end
            2'b11: begin
               if (e1_valid) begin
                  m_axis_tdata <= e1_data;
                  m_axis_tkeep <= e1_keep;
                  m_axis_tlast <= e1_last;
                  e1_data      <= in_data;
                  e1_keep      <= in_keep;
                  e1_last      <= in_last;
               end else begin
                  m_axis_tdata <= in_data;
                  m_axis_tkeep <= in_keep;
                  m_axis_tlast <= in_last;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_axis_c2h_arbiter.sv
// Randomized bench for axis_c2h_arbiter: per-cycle comparison against a
// queue-based round-robin / output-FIFO reference model.
module tb_axis_c2h_arbiter;

   localparam int N  = 4;
   localparam int DW = 128;
   localparam int KW = DW/8;
   localparam int GW = 2;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            arb_en = 1'b0;
   logic [N-1:0]    s_tvalid = '0;
   logic [N-1:0]    s_tready;
   logic [N*DW-1:0] s_tdata = '0;
   logic [N*KW-1:0] s_tkeep = '0;
   logic [N-1:0]    s_tlast = '0;
   logic            m_tvalid;
   logic            m_tready = 1'b0;
   logic [DW-1:0]   m_tdata;
   logic [KW-1:0]   m_tkeep;
   logic            m_tlast;
   logic            g_valid;
   logic [GW-1:0]   g_idx;
   logic [31:0]     pkt_cnt;

   axis_c2h_arbiter #(.N_REQ(N), .C_DATA_WIDTH(DW)) dut (
      .axis_aclk     (clk),
      .axis_areset   (rst),
      .arb_en        (arb_en),
      .s_axis_tvalid (s_tvalid),
      .s_axis_tready (s_tready),
      .s_axis_tdata  (s_tdata),
      .s_axis_tkeep  (s_tkeep),
      .s_axis_tlast  (s_tlast),
      .m_axis_tvalid (m_tvalid),
      .m_axis_tready (m_tready),
      .m_axis_tdata  (m_tdata),
      .m_axis_tkeep  (m_tkeep),
      .m_axis_tlast  (m_tlast),
      .grant_valid   (g_valid),
      .grant_idx     (g_idx),
      .pkt_cnt       (pkt_cnt)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic          last;
      logic [KW-1:0] keep;
      logic [DW-1:0] data;
   } beat_t;

   beat_t       q[$];
   bit          m_busy, m_room;
   int          m_gidx, m_last, acc_port;
   logic [31:0] m_pkt;

   int          src_beat[N], src_len[N];
   int unsigned src_seq[N];
   bit          stopping;
   int          vpct, rpct, flip_pct;

   int unsigned n_checks = 0, n_fail = 0;

   task automatic check_eq(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_busy   = 1'b0;
      m_room   = 1'b1;
      m_gidx   = 0;
      m_last   = N-1;
      m_pkt    = '0;
      acc_port = -1;
      s_tvalid = '0;
      for (int i = 0; i < N; i++) begin
         src_beat[i] = 0;
         src_len[i]  = $urandom_range(1, 6);
      end
   endtask

   task automatic check_reset_vals();
      check_eq("rst_s_tready", s_tready, '0);
      check_eq("rst_m_tvalid", m_tvalid, '0);
      check_eq("rst_m_tdata", m_tdata, '0);
      check_eq("rst_m_tkeep", m_tkeep, '0);
      check_eq("rst_m_tlast", m_tlast, '0);
      check_eq("rst_grant_valid", g_valid, '0);
      check_eq("rst_grant_idx", g_idx, '0);
      check_eq("rst_pkt_cnt", pkt_cnt, '0);
   endtask

   // Compare DUT against the model for this cycle, then advance the model across the coming edge.
   task automatic model_step();
      logic [N-1:0] exp_rdy;
      beat_t b;
      exp_rdy = '0;
      if (m_busy) exp_rdy[m_gidx] = m_room;
      check_eq("s_tready", s_tready, exp_rdy);
      check_eq("m_tvalid", m_tvalid, (q.size() != 0));
      if (q.size() != 0) begin
         check_eq("m_tdata", m_tdata, q[0].data);
         check_eq("m_tkeep", m_tkeep, q[0].keep);
         check_eq("m_tlast", m_tlast, q[0].last);
      end
      check_eq("grant_valid", g_valid, m_busy);
      check_eq("grant_idx", g_idx, m_gidx);
      check_eq("pkt_cnt", pkt_cnt, m_pkt);

      acc_port = -1;
      if (q.size() != 0 && m_tready) begin
         if (q[0].last) m_pkt = m_pkt + 32'd1;
         void'(q.pop_front());
      end
      if (m_busy) begin
         if (m_room && s_tvalid[m_gidx]) begin
            b.last = s_tlast[m_gidx];
            b.keep = s_tkeep[m_gidx*KW +: KW];
            b.data = s_tdata[m_gidx*DW +: DW];
            q.push_back(b);
            acc_port = m_gidx;
            if (b.last) begin
               m_busy = 1'b0;
               m_last = m_gidx;
            end
         end
      end else if (arb_en && (s_tvalid != '0)) begin
         for (int k = 1; k <= N; k++) begin
            if (s_tvalid[(m_last + k) % N]) begin
               m_gidx = (m_last + k) % N;
               break;
            end
         end
         m_busy = 1'b1;
      end
      m_room = (q.size() < 2);
   endtask

   task automatic drive();
      m_tready = ($urandom_range(0, 99) < rpct);
      if (flip_pct != 0 && $urandom_range(0, 99) < flip_pct) arb_en = ~arb_en;
      for (int i = 0; i < N; i++) begin
         if (acc_port == i) begin
            s_tvalid[i] = 1'b0;
            if (src_beat[i] == src_len[i]-1) begin
               src_beat[i] = 0;
               src_len[i]  = $urandom_range(1, 6);
               src_seq[i]++;
            end else begin
               src_beat[i]++;
            end
         end
         if (!s_tvalid[i] && !(stopping && src_beat[i] == 0) && $urandom_range(0, 99) < vpct) begin
            s_tvalid[i] = 1'b1;
            s_tdata[i*DW +: DW] = {$urandom(), $urandom(), $urandom(), 8'(i), 8'(src_beat[i]), 16'(src_seq[i])};
            s_tkeep[i*KW +: KW] = KW'($urandom_range(1, 16'hFFFF));
            s_tlast[i] = (src_beat[i] == src_len[i]-1);
         end
      end
   endtask

   task automatic cycle();
      @(negedge clk);
      model_step();
      @(posedge clk);
      #1;
      drive();
   endtask

   task automatic run_phase(input int cycles, input int v, input int r, input int f);
      vpct = v; rpct = r; flip_pct = f;
      if (f == 0) arb_en = 1'b1;
      repeat (cycles) cycle();
   endtask

   task automatic mid_reset();
      @(negedge clk);
      #2 rst = 1'b1;
      #1 check_reset_vals();
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1 drive();
   endtask

   initial begin
      int budget;
      for (int i = 0; i < N; i++) src_seq[i] = 0;
      stopping = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_vals();
      rst = 1'b0;
      @(posedge clk);
      #1;
      vpct = 100; rpct = 100; flip_pct = 0; arb_en = 1'b1;
      drive();

      run_phase(300, 100, 100, 0);
      run_phase(1500, 70, 50, 5);
      run_phase(400, 40, 30, 0);
      mid_reset();
      run_phase(600, 60, 60, 3);

      force dut.pkt_cnt = 32'hFFFF_FFFF;
      #1 release dut.pkt_cnt;
      m_pkt = 32'hFFFF_FFFF;
      vpct = 90; rpct = 80; flip_pct = 0; arb_en = 1'b1;
      budget = 0;
      while (m_pkt != 32'd0 && budget < 3000) begin
         cycle();
         budget++;
      end
      check_eq("pkt_wrap", pkt_cnt, 32'd0);

      run_phase(800, 50, 70, 4);

      stopping = 1'b1; flip_pct = 0; arb_en = 1'b1; rpct = 100;
      budget = 0;
      while ((m_busy || q.size() != 0 || s_tvalid != '0) && budget < 2000) begin
         cycle();
         budget++;
      end
      check_eq("drain_done", (budget < 2000), 1'b1);
      repeat (3) cycle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not end by %0t", $time);
      $fatal(1);
   end

endmodule

// File: doc/axis_c2h_arbiter.md
Name: axis_c2h_arbiter

Overview:
- Packet-granular round-robin arbiter that shares the single XDMA C2H AXI-Stream channel (s_axis_c2h_*_0 on the XDMA core) among N_REQ upstream stream sources: loopback FIFO, accelerator result streams, status generators.
- Sits between the requesters and the XDMA C2H port in the axi_clk domain.
- Guarantees packets are never interleaved.
- Provides a registered, full-throughput output stage and grant/status visibility.

Parameters:
- N_REQ, 4, number of requester streams (2..16).
- C_DATA_WIDTH, 128, tdata width in bits; tkeep is C_DATA_WIDTH/8.
- GRANT_W, $clog2(N_REQ), grant index width (derived, not overridden).

Ports:
- axis_aclk  input  1  stream clock (XDMA axi_aclk).
- axis_areset  input  1  asynchronous, active-high reset.
- arb_en  input  1  1 = new grants allowed; 0 = finish current packet, then hold idle.
- s_axis_tvalid  input  N_REQ  per-requester valid.
- s_axis_tready  output  N_REQ  per-requester ready.
- s_axis_tdata  input  N_REQ*C_DATA_WIDTH  packed data; requester i uses slice i.
- s_axis_tkeep  input  N_REQ*C_DATA_WIDTH/8  packed keep.
- s_axis_tlast  input  N_REQ  per-requester last.
- m_axis_tvalid  output  1  to XDMA C2H tvalid.
- m_axis_tready  input  1  from XDMA C2H tready.
- m_axis_tdata  output  C_DATA_WIDTH  to XDMA C2H tdata.
- m_axis_tkeep  output  C_DATA_WIDTH/8  to XDMA C2H tkeep.
- m_axis_tlast  output  1  to XDMA C2H tlast.
- grant_valid  output  1  high while in XFER.
- grant_idx  output  GRANT_W  index of the current or most recent grant.
- pkt_cnt  output  32  count of packets fully accepted on m_axis; wraps at 2^32.

Behaviour:
- Reset (async assert, release sampled on axis_aclk):
  - State is IDLE.
  - s_axis_tready = 0, m_axis_tvalid = 0, m_axis_tdata/tkeep/tlast = 0.
  - grant_valid = 0, grant_idx = 0, pkt_cnt = 0.
  - Skid buffer is empty; internal last_grant = N_REQ-1, so port 0 has first priority.
- FSM has two states, IDLE and XFER.
- IDLE:
  - All s_axis_tready = 0.
  - If arb_en=1 and any s_axis_tvalid=1, select the first asserted valid searching from (last_grant+1) mod N_REQ upward, wrapping.
  - Register grant_idx, set grant_valid=1, go to XFER next cycle.
  - This costs exactly one arbitration bubble cycle per packet.
- XFER:
  - s_axis_tready[grant_idx] = skid buffer not full; all other readies = 0.
  - A beat is accepted when that requester's tvalid & tready are both high; it is forwarded with its tkeep/tlast unmodified.
  - On an accepted beat with tlast=1: last_grant <= grant_idx, grant_valid <= 0, return to IDLE.
  - grant_idx holds its value after the packet ends.
- arb_en deasserted during XFER does not truncate the packet. It only blocks the next grant.
- A requester dropping tvalid mid-packet keeps the grant. No timeout; the arbiter waits indefinitely.
- Output stage is a 2-entry skid buffer:
  - m_axis_* are driven from registers only.
  - Latency from input acceptance to m_axis_tvalid is 1 cycle.
  - Sustains 1 beat/cycle when m_axis_tready=1.
  - The not-full condition for s_axis_tready is registered, so there is no combinational tready path from m_axis_tready to s_axis_tready.
  - Holds m_axis_tdata/tkeep/tlast stable while m_axis_tvalid=1 and m_axis_tready=0.
- Simultaneous events:
  - An input beat accepted and an output beat taken in the same cycle leave occupancy unchanged.
  - The tlast beat accepted while the buffer is draining is fine; IDLE arbitration may proceed while the buffer still holds data.
- pkt_cnt increments on m_axis_tvalid & m_axis_tready & m_axis_tlast; 0xFFFFFFFF wraps to 0.
- Reset asserted mid-packet aborts immediately to reset values. The partial packet is discarded; upstream/XDMA reset together with it.
- For N_REQ=1, grant_idx is 1 bit and always 0.

Test Plan:
- Single requester: port 2 sends a 4-beat packet, m_axis_tready=1 -> grant_idx=2 one cycle after tvalid; m_axis shows 4 beats with identical data/keep; tlast on beat 4; pkt_cnt=1.
- All 4 ports continuously valid with 2-beat packets -> grant order 0,1,2,3,0; no interleaving; one bubble cycle between packets; pkt_cnt=5 after 5 packets.
- m_axis_tready toggles 1,0,0,1 during a 6-beat packet -> no beat lost or duplicated; data stable while stalled; skid buffer never accepts a 3rd entry.
- Port 1 mid-packet with arb_en dropped to 0 after beat 2 of 5 -> beats 3..5 complete; port 3 pending valid receives no grant until arb_en=1.
- Port 0 deasserts tvalid for 10 cycles mid-packet while port 1 is valid -> grant stays 0; port 1 tready stays 0 until port 0's tlast is accepted.
- Reset pulse during beat 3 of 8 -> next cycle all outputs at reset values; after release port 0 wins first; preload pkt_cnt to 0xFFFFFFFF via 2^32-1 packets (or force) -> next packet gives 0.
